// File: rtl/uart_pkg.sv
// Types and defaults shared by the UART receive and transmit sides.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;
endpackage

// File: rtl/uart_rx_core_if.sv
// Byte delivery bus from the UART receiver: valid/ready data path plus error pulses.
// The master holds data_out/data_valid until the slave raises data_ready.
interface uart_rx_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_err;
    logic                 overrun_err;

    modport master (
        output data_out, data_valid, frame_err, overrun_err,
        input  data_ready
    );

    modport slave (
        input  data_out, data_valid, frame_err, overrun_err,
        output data_ready
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser for the async rx pin; SYNC_STAGES cycles latency, no backpressure.
// Presets to 1 (line idle) so reset never looks like a start bit.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);
    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk) begin
        if (!reset) sync_ff <= '1;
        else        sync_ff <= {sync_ff[SYNC_STAGES-2:0], rx};
    end

    assign rx_s = sync_ff[SYNC_STAGES-1];
endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: byte valid 1 clk after the mid-stop sample (sync + 9.5 bit periods from start edge).
// Holds the byte until data_ready; a byte finishing while the previous is still pending is dropped with overrun_err.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  rx,
    uart_rx_core_if.master        bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 half_done, full_done;
    logic                 sample_bit, deliver, frame_bad;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .rx_s (rx_s)
    );

    assign half_done = tick && (tick_cnt == HALF_LAST);
    assign full_done = tick && (tick_cnt == FULL_LAST);

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!rx_s)     state_d = START;
            START:   if (half_done) state_d = rx_s ? IDLE : DATA;
            DATA:    if (full_done && bit_cnt == LAST_BIT) state_d = STOP;
            STOP:    if (full_done) state_d = rx_s ? IDLE : BREAK;
            BREAK:   if (rx_s)      state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        sample_bit = 1'b0;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        if (state_q == DATA && full_done) sample_bit = 1'b1;
        if (state_q == STOP && full_done) begin
            deliver   = rx_s;
            frame_bad = !rx_s;
        end
    end

    // Counters restart on every state change so each state measures from its own entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (state_d != state_q) begin
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (tick) begin
                if (tick_cnt == FULL_LAST) begin
                    tick_cnt <= '0;
                    if (state_q == DATA) bit_cnt <= bit_cnt + BW'(1);
                end else begin
                    tick_cnt <= tick_cnt + TW'(1);
                end
            end
            if (sample_bit) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.data_out    <= '0;
            bus.data_valid  <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.overrun_err <= 1'b0;
        end else begin
            bus.frame_err   <= frame_bad;
            bus.overrun_err <= deliver && bus.data_valid && !bus.data_ready;
            if (deliver && (!bus.data_valid || bus.data_ready)) begin
                bus.data_out   <= shift_reg;
                bus.data_valid <= 1'b1;
            end else if (bus.data_valid && bus.data_ready) begin
                bus.data_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core with tick held high: directed corner cases, a vector table and random frames.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int DB  = UART_DATA_BITS;
    localparam int OS  = UART_OVERSAMPLE;
    localparam int SS  = 2;
    // Clock edges from the first edge that sees rx low to the edge raising data_valid.
    localparam int LAT = SS + OS / 2 + OS * (DB + 1);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tick  = 1'b1;
    logic rx    = 1'b1;

    uart_rx_core_if #(.DATA_BITS(DB)) bus ();

    uart_rx_core #(.DATA_BITS(DB), .OVERSAMPLE(OS), .SYNC_STAGES(SS)) dut (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .rx   (rx),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    int n_ferr = 0, n_ovr = 0, n_rise = 0, n_vcyc = 0, rise_cyc = -1;
    logic prev_v = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (bus.data_valid && bus.data_ready) got_q.push_back(bus.data_out);
            if (bus.frame_err)   n_ferr++;
            if (bus.overrun_err) n_ovr++;
            if (bus.data_valid)  n_vcyc++;
            if (bus.data_valid && !prev_v) begin
                n_rise++;
                rise_cyc = cyc;
            end
            prev_v = bus.data_valid;
        end else begin
            prev_v = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    int n_chk = 0, n_fail = 0, rd = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic expect_byte(input string nm, input logic [7:0] exp);
        int act;
        act = (rd < got_q.size()) ? int'(got_q[rd]) : 'h100;
        if (rd < got_q.size()) rd++;
        chk(nm, act, int'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame starting now (called 1 time unit after a posedge); optional low hold after the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int hold);
        rx = 1'b0;
        idle(OS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            idle(OS);
        end
        rx = stop;
        idle(OS);
        if (hold > 0) begin
            rx = 1'b0;
            idle(hold);
        end
        rx = 1'b1;
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         exp_rise;
        logic [7:0] exp_d;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[7];
    logic [7:0] exp_q[$];
    int f0, r0, v0, o0, e0, exp_ferr_cnt, base;
    logic [7:0] rb;
    logic rs;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
        vecs[2] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
        vecs[3] = '{8'h80, 1'b1, 1, 8'h80, 0};
        vecs[4] = '{8'h01, 1'b1, 1, 8'h01, 0};
        vecs[5] = '{8'hAA, 1'b0, 0, 8'h00, 1};
        vecs[6] = '{8'h3C, 1'b1, 1, 8'h3C, 0};

        bus.data_ready = 1'b1;
        idle(3);
        chk("reset data_out",    int'(bus.data_out), 0);
        chk("reset data_valid",  int'(bus.data_valid), 0);
        chk("reset frame_err",   int'(bus.frame_err), 0);
        chk("reset overrun_err", int'(bus.overrun_err), 0);
        reset = 1'b1;
        idle(4);

        // Basic frame with latency and single-cycle valid
        r0 = n_rise; v0 = n_vcyc; o0 = n_ovr; e0 = n_ferr; f0 = cyc;
        send_frame(8'hA5, 1'b1, 0);
        idle(4);
        expect_byte("t1 data", 8'hA5);
        chk("t1 valid cycles", n_vcyc - v0, 1);
        chk("t1 valid rise cycle", rise_cyc, f0 + 1 + LAT);
        chk("t1 frame_err", n_ferr - e0, 0);
        chk("t1 overrun_err", n_ovr - o0, 0);

        foreach (vecs[k]) begin
            r0 = n_rise; e0 = n_ferr;
            send_frame(vecs[k].d, vecs[k].stop, 0);
            idle(6);
            chk($sformatf("vec%0d valid rises", k), n_rise - r0, vecs[k].exp_rise);
            if (vecs[k].exp_rise != 0) expect_byte($sformatf("vec%0d data", k), vecs[k].exp_d);
            chk($sformatf("vec%0d frame_err", k), n_ferr - e0, vecs[k].exp_ferr);
        end

        // Short start glitch is ignored
        r0 = n_rise; o0 = n_ovr; e0 = n_ferr;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(30);
        chk("t2 glitch valid", n_rise - r0, 0);
        chk("t2 glitch errors", (n_ferr - e0) + (n_ovr - o0), 0);
        send_frame(8'h3C, 1'b1, 0);
        idle(4);
        expect_byte("t2 data", 8'h3C);

        // Bad stop bit then held-low line
        r0 = n_rise; e0 = n_ferr;
        send_frame(8'h55, 1'b0, 40);
        idle(4);
        chk("t3 frame_err pulses", n_ferr - e0, 1);
        chk("t3 no valid", n_rise - r0, 0);
        send_frame(8'h0F, 1'b1, 0);
        idle(4);
        expect_byte("t3 data", 8'h0F);

        // Overrun with byte held
        bus.data_ready = 1'b0;
        o0 = n_ovr; e0 = n_ferr;
        send_frame(8'h11, 1'b1, 0);
        idle(4);
        send_frame(8'h22, 1'b1, 0);
        idle(4);
        chk("t4 data_out held", int'(bus.data_out), 'h11);
        chk("t4 data_valid held", int'(bus.data_valid), 1);
        chk("t4 overrun pulses", n_ovr - o0, 1);
        chk("t4 frame_err", n_ferr - e0, 0);
        bus.data_ready = 1'b1;
        idle(2);
        expect_byte("t4 consumed", 8'h11);
        chk("t4 valid dropped", int'(bus.data_valid), 0);
        chk("t4 dropped byte absent", got_q.size() - rd, 0);

        // Accept exactly on the completing cycle
        bus.data_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        idle(4);
        r0 = n_rise; o0 = n_ovr;
        fork
            send_frame(8'h22, 1'b1, 0);
            begin
                repeat (LAT) @(posedge clk);
                #1 bus.data_ready = 1'b1;
            end
        join
        idle(4);
        expect_byte("t5 first", 8'h11);
        expect_byte("t5 second", 8'h22);
        chk("t5 overrun", n_ovr - o0, 0);
        chk("t5 valid stayed high", n_rise - r0, 0);

        // Reset in the middle of bit 4 (upper nibble of 0xF0 is high, so the remainder idles)
        bus.data_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 0);
        idle(4);
        chk("t6 pending before reset", int'(bus.data_valid), 1);
        fork
            send_frame(8'hF0, 1'b1, 0);
            begin
                repeat (OS * 5 + OS / 2) @(posedge clk);
                #1 reset = 1'b0;
                idle(1);
                chk("t6 reset data_out",    int'(bus.data_out), 0);
                chk("t6 reset data_valid",  int'(bus.data_valid), 0);
                chk("t6 reset frame_err",   int'(bus.frame_err), 0);
                chk("t6 reset overrun_err", int'(bus.overrun_err), 0);
                reset = 1'b1;
            end
        join
        bus.data_ready = 1'b1;
        idle(20);
        chk("t6 no stray byte", got_q.size() - rd, 0);
        send_frame(8'hC3, 1'b1, 0);
        idle(4);
        expect_byte("t6 data", 8'hC3);

        // Random frames against the reference queue
        e0 = n_ferr;
        exp_ferr_cnt = 0;
        base = rd;
        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            if (rs) exp_q.push_back(rb);
            else    exp_ferr_cnt++;
            send_frame(rb, rs, 0);
            idle($urandom_range(4, 30));
        end
        chk("rand byte count", got_q.size() - base, exp_q.size());
        chk("rand frame_err count", n_ferr - e0, exp_ferr_cnt);
        foreach (exp_q[i]) expect_byte($sformatf("rand byte %0d", i), exp_q[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
